// File: rtl/param_array_if.sv
// param_array_if: request/response bundle between a cache datapath and its storage array
interface param_array_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int GRAN  = 8
);
  localparam int LANES = WIDTH / GRAN;
  localparam int AW = $clog2(DEPTH);
  logic             flush;
  logic             load;
  logic [LANES-1:0] wmask;
  logic [AW-1:0]    windex;
  logic [WIDTH-1:0] datain;
  logic [AW-1:0]    rindex;
  logic [WIDTH-1:0] dataout;
  logic             ready;
  modport master(output flush, load, wmask, windex, datain, rindex, input dataout, ready);
  modport slave(input flush, load, wmask, windex, datain, rindex, output dataout, ready);
endinterface

// File: rtl/param_array.sv
// param_array: lane-masked storage array with write-to-read bypass and self-clearing sweep
module param_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int GRAN  = 8
) (
  input logic         clk,
  input logic         rst,
  param_array_if.slave bus
);
  localparam int LANES = WIDTH / GRAN;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t           state, state_d;
  logic [AW-1:0]    cnt, cnt_d;
  logic             clr_we, wr_en, bypass;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd;
  // next-state: sweep entries one per edge; flush restarts the sweep and beats any load
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    clr_we = 1'b0;
    wr_en = 1'b0;
    if (state == CLEAR) begin
      clr_we = 1'b1;
      cnt_d = bus.flush ? '0 : cnt + 1'b1;
      state_d = (!bus.flush && cnt == AW'(DEPTH - 1)) ? READY : CLEAR;
    end else if (bus.flush) begin
      state_d = CLEAR;
      cnt_d = '0;
    end else begin
      wr_en = bus.load;
    end
  end
  // state register; reset restarts the sweep from entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  end
  // storage: clear writes from the sweep, lane-masked writes when ready; nothing on a reset edge
  always_ff @(posedge clk) begin
    if (!rst && clr_we) mem[cnt] <= '0;
    else if (!rst && wr_en)
      for (int i = 0; i < LANES; i++)
        if (bus.wmask[i]) mem[bus.windex][i*GRAN +: GRAN] <= bus.datain[i*GRAN +: GRAN];
  end
  assign bus.ready = (state == READY) && !rst;
  assign bypass = bus.ready && bus.load && (bus.rindex == bus.windex);
  // read path: stored word with same-cycle write lanes merged in, forced to zero while not ready
  always_comb begin
    rd = mem[bus.rindex];
    for (int i = 0; i < LANES; i++)
      if (bypass && bus.wmask[i]) rd[i*GRAN +: GRAN] = bus.datain[i*GRAN +: GRAN];
  end
  assign bus.dataout = bus.ready ? rd : '0;
endmodule

// File: tb/tb_param_array.sv
// tb_param_array: directed checks of clear sweep, masked writes, bypass, flush and reset restart
module tb_param_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  param_array_if #(.WIDTH(32), .DEPTH(8), .GRAN(8)) bus ();
  param_array #(.WIDTH(32), .DEPTH(8), .GRAN(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] m);
    bus.load = 1'b1;
    bus.windex = idx;
    bus.datain = d;
    bus.wmask = m;
    tick();
    bus.load = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    bus.rindex = idx;
    #1;
    chk(tag, bus.dataout, exp);
  endtask
  task automatic all_zero(input string tag);
    for (int i = 0; i < 8; i++) rd(tag, 3'(i), 32'h0);
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.load = 1'b0;
    bus.wmask = 4'h0;
    bus.windex = 3'd0;
    bus.datain = 32'h0;
    bus.rindex = 3'd0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_dout", bus.dataout, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("init_ready%0d", k), 32'(bus.ready), k == 8 ? 32'd1 : 32'd0);
    end
    all_zero("init_zero");
    wr(3'd3, 32'hDEADBEEF, 4'hF);
    wr(3'd3, 32'h11223344, 4'b0101);
    rd("mask_merge", 3'd3, 32'hDE22BE44);
    wr(3'd5, 32'hAAAAAAAA, 4'hF);
    bus.load = 1'b1;
    bus.windex = 3'd5;
    bus.rindex = 3'd5;
    bus.datain = 32'h55555555;
    bus.wmask = 4'b0011;
    #1;
    chk("bypass_comb", bus.dataout, 32'hAAAA5555);
    tick();
    bus.load = 1'b0;
    rd("bypass_store", 3'd5, 32'hAAAA5555);
    wr(3'd3, 32'h12345678, 4'h0);
    rd("mask_none", 3'd3, 32'hDE22BE44);
    wr(3'd7, 32'h77777777, 4'hF);
    wr(3'd0, 32'h000000A0, 4'hF);
    rd("wrap0", 3'd0, 32'h000000A0);
    rd("wrap1", 3'd1, 32'h0);
    rd("wrap2", 3'd2, 32'h0);
    rd("wrap3", 3'd3, 32'hDE22BE44);
    rd("wrap4", 3'd4, 32'h0);
    rd("wrap5", 3'd5, 32'hAAAA5555);
    rd("wrap6", 3'd6, 32'h0);
    rd("wrap7", 3'd7, 32'h77777777);
    for (int i = 0; i < 8; i++) wr(3'(i), 32'hF0F0F0F0 + 32'(i), 4'hF);
    rd("fill2", 3'd2, 32'hF0F0F0F2);
    bus.flush = 1'b1;
    bus.load = 1'b1;
    bus.windex = 3'd0;
    bus.datain = 32'h1;
    bus.wmask = 4'hF;
    tick();
    bus.flush = 1'b0;
    bus.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("flush_low%0d", k), 32'(bus.ready), 32'd0);
      tick();
    end
    chk("flush_ready", 32'(bus.ready), 32'd1);
    all_zero("flush_zero");
    wr(3'd6, 32'hCAFEF00D, 4'hF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.load = 1'b1;
    bus.wmask = 4'hF;
    bus.datain = 32'hBAD0BAD0;
    for (int k = 0; k < 4; k++) begin
      bus.windex = 3'(k + 4);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd0);
    chk("mid_rst_dout", bus.dataout, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.windex = 3'(k);
      chk($sformatf("restart_low%0d", k), 32'(bus.ready), 32'd0);
      tick();
    end
    bus.load = 1'b0;
    chk("restart_ready", 32'(bus.ready), 32'd1);
    all_zero("restart_zero");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
